// File: rtl/sap_obi_slave_cut.sv
// OBI pipeline cut for one crossbar slave port. Requests are buffered in a
// small FIFO, responses go through a one-cycle register, and the number of
// transactions in flight is capped so a slow slave cannot pile them up.
// Transaction order is preserved end to end.

package sap_obi_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module sap_obi_slave_cut #(
  parameter int unsigned  REQ_DEPTH       = 2,
  parameter int unsigned  MAX_OUTSTANDING = 4,
  parameter type          obi_req_t       = sap_obi_pkg::obi_req_t,
  parameter type          obi_resp_t      = sap_obi_pkg::obi_resp_t,
  localparam int unsigned OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  obi_req_t         master_req_i,
  output obi_resp_t        master_resp_o,
  output obi_req_t         slave_req_o,
  input  obi_resp_t        slave_resp_i,
  output logic [OUT_W-1:0] outstanding_o,
  output logic             idle_o
);

  localparam int unsigned PTR_W = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(REQ_DEPTH + 1);
  // req is the MSB of the request struct; everything below it is payload
  localparam int unsigned PAY_W = $bits(obi_req_t) - 1;

  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(REQ_DEPTH);
  localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(REQ_DEPTH - 1);

  logic [PAY_W-1:0] fifo_mem [REQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic [OUT_W-1:0] out_cnt;
  logic             rvalid_p1;
  logic [31:0]      rdata_p1;

  logic fifo_empty;
  logic fifo_full;
  logic out_full;
  logic m_gnt;
  logic push;
  logic pop;

  // Step the in-flight count; a decrement at zero is dropped, never wrapped
  function automatic logic [OUT_W-1:0] out_next(input logic [OUT_W-1:0] cur,
                                                input logic             inc,
                                                input logic             dec);
    logic [OUT_W-1:0] nxt;
    nxt = cur;
    if (inc && !dec) begin
      if (cur != MAX_OUT_C) nxt = cur + 1'b1;
    end else if (dec && !inc) begin
      if (cur != '0) nxt = cur - 1'b1;
    end
    return nxt;
  endfunction

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == DEPTH_C);
  assign out_full   = (out_cnt == MAX_OUT_C);

  // Grant depends only on registered state and req; held low while in reset
  assign m_gnt = rst_ni && master_req_i.req && !fifo_full && !out_full;
  assign push  = m_gnt;
  assign pop   = !fifo_empty && slave_resp_i.gnt;

  assign outstanding_o = out_cnt;
  assign idle_o        = fifo_empty && (out_cnt == '0);

  // Upstream response: combinational grant, registered rvalid/rdata
  always_comb begin
    master_resp_o        = '0;
    master_resp_o.gnt    = m_gnt;
    master_resp_o.rvalid = rvalid_p1;
    master_resp_o.rdata  = rdata_p1;
  end

  // Downstream request presents the FIFO head, all zero when empty
  always_comb begin
    slave_req_o = '0;
    if (!fifo_empty) slave_req_o = obi_req_t'({1'b1, fifo_mem[rd_ptr]});
  end

  // FIFO storage: payload only, no reset needed
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= master_req_i[PAY_W-1:0];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  // Response register: rvalid delayed one cycle, rdata captured only on rvalid
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_p1 <= 1'b0;
      rdata_p1  <= '0;
    end else begin
      rvalid_p1 <= slave_resp_i.rvalid;
      if (slave_resp_i.rvalid) rdata_p1 <= slave_resp_i.rdata;
    end
  end

  // In-flight counter: up on upstream accept, down on upstream rvalid
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) out_cnt <= '0;
    else         out_cnt <= out_next(out_cnt, push, rvalid_p1);
  end

endmodule

// File: tb/tb_sap_obi_slave_cut.sv
// Bench for sap_obi_slave_cut: table-driven single-read vectors plus
// scoreboarded sequences for throughput, backpressure, in-flight cap,
// reset mid-flight and simultaneous push/pop/rvalid.
module tb_sap_obi_slave_cut;
  import sap_obi_pkg::*;

  localparam int REQ_DEPTH = 2;
  localparam int MAX_OUT   = 4;

  logic      clk = 1'b0;
  logic      rst_ni;
  obi_req_t  master_req_i;
  obi_resp_t master_resp_o;
  obi_req_t  slave_req_o;
  obi_resp_t slave_resp_i;
  logic [2:0] outstanding_o;
  logic      idle_o;

  always #5 clk = ~clk;

  sap_obi_slave_cut #(.REQ_DEPTH(REQ_DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .master_req_i (master_req_i),
    .master_resp_o(master_resp_o),
    .slave_req_o  (slave_req_o),
    .slave_resp_i (slave_resp_i),
    .outstanding_o(outstanding_o),
    .idle_o       (idle_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- single-read vector table ----------------
  typedef struct {
    logic        mreq;
    logic        mwe;
    logic [31:0] maddr;
    logic        sgnt;
    logic        srv;
    logic [31:0] srdata;
    logic [31:0] e_gnt;
    logic [31:0] e_sreq;
    logic [31:0] e_saddr;
    logic [31:0] e_rv;
    logic [31:0] e_rdata;
    logic [31:0] e_out;
    logic [31:0] e_idle;
  } vec_t;

  vec_t tbl [6];

  task automatic run_table(input string tag);
    for (int i = 0; i < 6; i++) begin
      master_req_i        = '0;
      master_req_i.req    = tbl[i].mreq;
      master_req_i.we     = tbl[i].mwe;
      master_req_i.be     = 4'hF;
      master_req_i.addr   = tbl[i].maddr;
      slave_resp_i        = '0;
      slave_resp_i.gnt    = tbl[i].sgnt;
      slave_resp_i.rvalid = tbl[i].srv;
      slave_resp_i.rdata  = tbl[i].srdata;
      @(negedge clk);
      chk($sformatf("%s_c%0d_gnt", tag, i),    32'(master_resp_o.gnt),    tbl[i].e_gnt);
      chk($sformatf("%s_c%0d_sreq", tag, i),   32'(slave_req_o.req),      tbl[i].e_sreq);
      chk($sformatf("%s_c%0d_saddr", tag, i),  slave_req_o.addr,          tbl[i].e_saddr);
      chk($sformatf("%s_c%0d_rvalid", tag, i), 32'(master_resp_o.rvalid), tbl[i].e_rv);
      chk($sformatf("%s_c%0d_rdata", tag, i),  master_resp_o.rdata,       tbl[i].e_rdata);
      chk($sformatf("%s_c%0d_out", tag, i),    32'(outstanding_o),        tbl[i].e_out);
      chk($sformatf("%s_c%0d_idle", tag, i),   32'(idle_o),               tbl[i].e_idle);
      @(posedge clk); #1;
    end
    master_req_i = '0;
    slave_resp_i = '0;
  endtask

  // ---------------- scoreboard and slave model ----------------
  typedef struct {
    int          due;
    logic [31:0] rdata;
  } pend_t;

  obi_req_t    sb_req [$];
  logic [31:0] sb_rd  [$];
  pend_t       pend   [$];

  int          cyc = 0;
  int          rsp_delay, idx, n_req;
  logic [31:0] base_addr;
  logic        base_we;
  int          total_acc, total_rv, first_rv_acc, gnt_low, max_out;
  obi_req_t    s_snap;
  obi_resp_t   m_snap;
  int          out_snap, cnt_snap;
  logic        acc_snap;

  function automatic logic [31:0] slv_rdata(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic obi_req_t mk_req(input int i);
    obi_req_t r;
    r       = '0;
    r.req   = 1'b1;
    r.we    = base_we;
    r.be    = 4'hF;
    r.addr  = base_addr + 32'(i * 4);
    r.wdata = 32'hC0DE_0000 + 32'(i);
    return r;
  endfunction

  task automatic start(input logic [31:0] base, input logic we, input int n, input int d);
    base_addr    = base;
    base_we      = we;
    n_req        = n;
    rsp_delay    = d;
    idx          = 0;
    total_acc    = 0;
    total_rv     = 0;
    first_rv_acc = -1;
    gnt_low      = 0;
    max_out      = 0;
  endtask

  task automatic drive_req(input bit on);
    if (on && idx < n_req) master_req_i = mk_req(idx);
    else                   master_req_i = '0;
  endtask

  // One cycle: observe at negedge, then advance and drive the slave response
  task automatic step();
    obi_req_t exp_r;
    @(negedge clk);
    s_snap   = slave_req_o;
    m_snap   = master_resp_o;
    out_snap = int'(outstanding_o);
    cnt_snap = int'(dut.fifo_cnt);
    acc_snap = master_req_i.req && master_resp_o.gnt;
    if (out_snap > max_out) max_out = out_snap;
    if (master_req_i.req && !master_resp_o.gnt) gnt_low++;
    if (master_resp_o.rvalid) begin
      total_rv++;
      if (first_rv_acc < 0) first_rv_acc = total_acc + (acc_snap ? 1 : 0);
      if (sb_rd.size() == 0) begin
        checks++; errors++;
        $display("FAIL rvalid_unexpected: got rvalid=1 expected no response pending");
      end else begin
        chk("rdata_order", master_resp_o.rdata, sb_rd.pop_front());
      end
    end
    if (slave_req_o.req && slave_resp_i.gnt) begin
      if (sb_req.size() == 0) begin
        checks++; errors++;
        $display("FAIL slv_unexpected: got request addr=0x%08h expected none", slave_req_o.addr);
      end else begin
        exp_r = sb_req.pop_front();
        chk("slv_addr",  slave_req_o.addr,      exp_r.addr);
        chk("slv_wdata", slave_req_o.wdata,     exp_r.wdata);
        chk("slv_we",    32'(slave_req_o.we),   32'(exp_r.we));
        chk("slv_be",    32'(slave_req_o.be),   32'(exp_r.be));
      end
      pend.push_back('{cyc + rsp_delay, slv_rdata(slave_req_o.addr)});
    end
    if (acc_snap) begin
      sb_req.push_back(master_req_i);
      sb_rd.push_back(slv_rdata(master_req_i.addr));
      total_acc++;
      idx++;
    end
    @(posedge clk); #1;
    cyc++;
    slave_resp_i.rvalid = 1'b0;
    slave_resp_i.rdata  = 32'h0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      slave_resp_i.rvalid = 1'b1;
      slave_resp_i.rdata  = pend[0].rdata;
      void'(pend.pop_front());
    end
  endtask

  task automatic run_until_done(input int limit, input string tag);
    int k;
    k = 0;
    while (!(idx >= n_req && sb_rd.size() == 0 && pend.size() == 0 &&
             idle_o === 1'b1 && slave_resp_i.rvalid === 1'b0)) begin
      if (k >= limit) begin
        checks++; errors++;
        $display("FAIL %s_timeout: got %0d of %0d responses after %0d cycles, expected all", tag, total_rv, n_req, k);
        break;
      end
      drive_req(1'b1);
      slave_resp_i.gnt = 1'b1;
      step();
      k++;
    end
    master_req_i = '0;
    chk({tag, "_idle_after"}, 32'(idle_o), 32'd1);
    chk({tag, "_rv_count"}, 32'(total_rv), 32'(n_req));
  endtask

  // ---------------- protocol monitor ----------------
  initial begin : mon
    obi_req_t prv_req;
    logic     prv_gnt;
    bit       prv_ok;
    prv_ok  = 1'b0;
    prv_gnt = 1'b0;
    prv_req = '0;
    forever begin
      @(negedge clk);
      if (rst_ni !== 1'b1) begin
        prv_ok = 1'b0;
      end else begin
        if (prv_ok && prv_req.req && !prv_gnt) begin
          checks++;
          if (slave_req_o !== prv_req) begin
            errors++;
            $display("FAIL slv_stable: got addr=0x%08h req=%0b expected addr=0x%08h req=1", slave_req_o.addr, slave_req_o.req, prv_req.addr);
          end
        end
        if (int'(outstanding_o) > MAX_OUT) begin
          checks++; errors++;
          $display("FAIL out_cap: got %0d expected <= %0d", outstanding_o, MAX_OUT);
        end
        if (int'(dut.fifo_cnt) > REQ_DEPTH) begin
          checks++; errors++;
          $display("FAIL fifo_overflow: got %0d expected <= %0d", dut.fifo_cnt, REQ_DEPTH);
        end
        if (master_resp_o.rvalid && outstanding_o == 3'd0) begin
          checks++; errors++;
          $display("FAIL spurious_rvalid: got rvalid with outstanding 0 expected outstanding > 0");
        end
        prv_ok  = 1'b1;
        prv_req = slave_req_o;
        prv_gnt = slave_resp_i.gnt;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    //           mreq mwe maddr          sgnt srv srdata        gnt sreq saddr          rv  rdata          out idle
    tbl[0] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        0, 0, 32'h0,          0, 32'h0,          0, 1};
    tbl[1] = '{1'b1, 1'b0, 32'h1000_0040,1'b0, 1'b0, 32'h0,        1, 0, 32'h0,          0, 32'h0,          0, 1};
    tbl[2] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        0, 1, 32'h1000_0040,  0, 32'h0,          1, 0};
    tbl[3] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hDEAD_BEEF,0, 0, 32'h0,          0, 32'h0,          1, 0};
    tbl[4] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        0, 0, 32'h0,          1, 32'hDEAD_BEEF,  1, 0};
    tbl[5] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        0, 0, 32'h0,          0, 32'hDEAD_BEEF,  0, 1};

    rst_ni       = 1'b0;
    master_req_i = '0;
    slave_resp_i = '0;
    start(32'h0, 1'b0, 0, 1);
    master_req_i = mk_req(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt",    32'(master_resp_o.gnt),    32'd0);
    chk("rst_rvalid", 32'(master_resp_o.rvalid), 32'd0);
    chk("rst_rdata",  master_resp_o.rdata,       32'd0);
    chk("rst_sreq",   32'(slave_req_o.req),      32'd0);
    chk("rst_saddr",  slave_req_o.addr,          32'd0);
    chk("rst_out",    32'(outstanding_o),        32'd0);
    chk("rst_idle",   32'(idle_o),               32'd1);
    master_req_i = '0;
    #2 rst_ni = 1'b1;
    @(posedge clk); #1;

    run_table("rd1");

    // back-to-back writes at full throughput
    start(32'h0, 1'b1, 8, 1);
    for (int k = 0; k < 8; k++) begin
      drive_req(1'b1);
      slave_resp_i.gnt = 1'b1;
      step();
      chk($sformatf("b2b_gnt_%0d", k), 32'(acc_snap), 32'd1);
    end
    run_until_done(40, "b2b");

    // backpressure: slave withholds gnt for 5 cycles
    start(32'h3000, 1'b0, 4, 1);
    for (int k = 0; k < 5; k++) begin
      drive_req(1'b1);
      slave_resp_i.gnt = 1'b0;
      step();
      if (k >= 1) begin
        chk($sformatf("bp_sreq_%0d", k),  32'(s_snap.req), 32'd1);
        chk($sformatf("bp_saddr_%0d", k), s_snap.addr,     32'h3000);
      end
    end
    chk("bp_accepts",  32'(total_acc),  32'd2);
    chk("bp_gnt_low",  32'(m_snap.gnt), 32'd0);
    run_until_done(40, "bp");

    // in-flight cap with 10-cycle response delay
    start(32'h4000, 1'b0, 6, 10);
    run_until_done(80, "cap");
    chk("cap_max_out",      32'(max_out),      32'd4);
    chk("cap_acc_before_rv",32'(first_rv_acc), 32'd4);
    chk("cap_gnt_low",      32'(gnt_low),      32'd9);

    // simultaneous push, pop and upstream rvalid
    start(32'h5000, 1'b0, 3, 1);
    drive_req(1'b1); slave_resp_i.gnt = 1'b1; step();
    drive_req(1'b0); slave_resp_i.gnt = 1'b1; step();
    drive_req(1'b1); slave_resp_i.gnt = 1'b0; step();
    drive_req(1'b1); slave_resp_i.gnt = 1'b1; step();
    chk("sim_rvalid", 32'(m_snap.rvalid), 32'd1);
    chk("sim_accept", 32'(acc_snap),      32'd1);
    chk("sim_sreq",   32'(s_snap.req),    32'd1);
    chk("sim_cnt_pre",32'(cnt_snap),      32'd1);
    chk("sim_out_pre",32'(out_snap),      32'd2);
    drive_req(1'b0); slave_resp_i.gnt = 1'b1; step();
    chk("sim_cnt_post", 32'(cnt_snap), 32'd1);
    chk("sim_out_post", 32'(out_snap), 32'd2);
    run_until_done(40, "sim");

    // reset mid-flight with 2 FIFO entries and 3 outstanding
    start(32'h6000, 1'b0, 3, 20);
    drive_req(1'b1); slave_resp_i.gnt = 1'b1; step();
    drive_req(1'b1); slave_resp_i.gnt = 1'b1; step();
    drive_req(1'b1); slave_resp_i.gnt = 1'b0; step();
    chk("mrst_cnt_before", 32'(dut.fifo_cnt),  32'd2);
    chk("mrst_out_before", 32'(outstanding_o), 32'd3);
    master_req_i = mk_req(3);
    #2 rst_ni = 1'b0;
    #1;
    chk("mrst_sreq",   32'(slave_req_o.req),      32'd0);
    chk("mrst_rvalid", 32'(master_resp_o.rvalid), 32'd0);
    chk("mrst_gnt",    32'(master_resp_o.gnt),    32'd0);
    chk("mrst_out",    32'(outstanding_o),        32'd0);
    chk("mrst_idle",   32'(idle_o),               32'd1);
    sb_req.delete();
    sb_rd.delete();
    pend.delete();
    slave_resp_i = '0;
    @(negedge clk);
    master_req_i = '0;
    #2 rst_ni = 1'b1;
    @(posedge clk); #1;
    run_table("rd2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
